// File: rtl/atm_txn_ctrl.sv
// ATM transaction controller: PIN entry with retry limit, amount check against
// balance and per-transaction cap, note-by-note dispensing and inactivity timeouts.
module atm_txn_ctrl #(
    parameter int unsigned AMT_W         = 8,
    parameter int unsigned MAX_PIN_TRIES = 3,
    parameter int unsigned TIMEOUT_CYC   = 255,
    parameter int unsigned MAX_NOTES     = 40
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             card_inserted,
    input  logic             pin_valid,
    input  logic             pin_correct,
    input  logic             amt_valid,
    input  logic [AMT_W-1:0] amount,
    input  logic [AMT_W-1:0] balance,
    output logic             dispense_cash,
    output logic             card_eject,
    output logic             card_retained,
    output logic             txn_denied,
    output logic             txn_timeout,
    output logic             debit_valid,
    output logic [AMT_W-1:0] debit_amt,
    output logic             busy
);

    localparam int unsigned TRY_W = $clog2(MAX_PIN_TRIES + 1);
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [TRY_W-1:0] TRIES_LIM = TRY_W'(MAX_PIN_TRIES);
    localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(TIMEOUT_CYC);
    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
    localparam logic [AMT_W-1:0] NOTES_CAP = AMT_W'(MAX_NOTES);
    localparam logic [AMT_W-1:0] AMT_ONE   = AMT_W'(1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_PIN  = 3'd1;
    localparam logic [2:0] S_WAIT_AMT  = 3'd2;
    localparam logic [2:0] S_CHECK_BAL = 3'd3;
    localparam logic [2:0] S_DISPENSE  = 3'd4;
    localparam logic [2:0] S_EJECT     = 3'd5;
    localparam logic [2:0] S_LOCKED    = 3'd6;

    logic [2:0]       state_q,   state_d;
    logic [TRY_W-1:0] tries_q,   tries_d;
    logic [TMR_W-1:0] timer_q,   timer_d;
    logic [AMT_W-1:0] notes_q,   notes_d;
    logic [AMT_W-1:0] amt_q,     amt_d;
    logic [AMT_W-1:0] debit_amt_d;
    logic             denied_d;
    logic             timeout_d;
    logic             debit_d;
    logic [TRY_W-1:0] tries_inc;
    logic             amt_ok;

    assign tries_inc = tries_q + TRY_W'(1);
    assign amt_ok    = (amt_q != '0) && (amt_q <= balance) && (amt_q <= NOTES_CAP);

    // State, counters and registered outputs; outputs are decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            tries_q       <= '0;
            timer_q       <= '0;
            notes_q       <= '0;
            amt_q         <= '0;
            dispense_cash <= 1'b0;
            card_eject    <= 1'b0;
            card_retained <= 1'b0;
            txn_denied    <= 1'b0;
            txn_timeout   <= 1'b0;
            debit_valid   <= 1'b0;
            debit_amt     <= '0;
            busy          <= 1'b0;
        end else begin
            state_q       <= state_d;
            tries_q       <= tries_d;
            timer_q       <= timer_d;
            notes_q       <= notes_d;
            amt_q         <= amt_d;
            dispense_cash <= (state_d == S_DISPENSE);
            card_eject    <= (state_d == S_EJECT);
            card_retained <= (state_d == S_LOCKED);
            txn_denied    <= denied_d;
            txn_timeout   <= timeout_d;
            debit_valid   <= debit_d;
            debit_amt     <= debit_amt_d;
            busy          <= (state_d != S_IDLE);
        end
    end

    // Next-state and counter update; card removal beats strobes, strobes beat timeout
    always_comb begin
        state_d     = state_q;
        tries_d     = tries_q;
        timer_d     = timer_q;
        notes_d     = notes_q;
        amt_d       = amt_q;
        debit_amt_d = debit_amt;
        denied_d    = 1'b0;
        timeout_d   = 1'b0;
        debit_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (card_inserted) begin
                    state_d = S_WAIT_PIN;
                    tries_d = '0;
                    timer_d = TMR_LOAD;
                end
            end
            S_WAIT_PIN: begin
                if (!card_inserted) begin
                    state_d = S_IDLE;
                    tries_d = '0;
                    timer_d = '0;
                    notes_d = '0;
                    amt_d   = '0;
                end else if (pin_valid) begin
                    timer_d = TMR_LOAD;
                    if (pin_correct) begin
                        state_d = S_WAIT_AMT;
                    end else begin
                        tries_d = tries_inc;
                        if (tries_inc == TRIES_LIM) begin
                            state_d = S_LOCKED;
                        end
                    end
                end else if (timer_q <= TMR_ONE) begin
                    state_d   = S_EJECT;
                    timeout_d = 1'b1;
                    timer_d   = '0;
                end else begin
                    timer_d = timer_q - TMR_ONE;
                end
            end
            S_WAIT_AMT: begin
                if (!card_inserted) begin
                    state_d = S_IDLE;
                    tries_d = '0;
                    timer_d = '0;
                    notes_d = '0;
                    amt_d   = '0;
                end else if (amt_valid) begin
                    state_d = S_CHECK_BAL;
                    amt_d   = amount;
                    notes_d = amount;
                end else if (timer_q <= TMR_ONE) begin
                    state_d   = S_EJECT;
                    timeout_d = 1'b1;
                    timer_d   = '0;
                end else begin
                    timer_d = timer_q - TMR_ONE;
                end
            end
            S_CHECK_BAL: begin
                if (!card_inserted) begin
                    state_d = S_IDLE;
                    tries_d = '0;
                    timer_d = '0;
                    notes_d = '0;
                    amt_d   = '0;
                end else if (amt_ok) begin
                    state_d = S_DISPENSE;
                end else begin
                    state_d  = S_EJECT;
                    denied_d = 1'b1;
                end
            end
            S_DISPENSE: begin
                // Card removal is deliberately ignored so the note count always matches the debit
                if (notes_q <= AMT_ONE) begin
                    state_d     = S_EJECT;
                    notes_d     = '0;
                    debit_d     = 1'b1;
                    debit_amt_d = amt_q;
                end else begin
                    notes_d = notes_q - AMT_ONE;
                end
            end
            S_EJECT, S_LOCKED: begin
                if (!card_inserted) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_atm_txn_ctrl.sv
// Randomised scoreboard bench for atm_txn_ctrl: sessions push expected output
// events into a queue and a monitor pops and compares them as the DUT emits them.
module tb_atm_txn_ctrl;

    localparam int unsigned AMT_W = 8;
    localparam int TRIES = 3;
    localparam int TMO   = 4;
    localparam int CAP   = 40;

    localparam int EV_NOTE  = 1;
    localparam int EV_DEBIT = 2;
    localparam int EV_DENY  = 3;
    localparam int EV_TMO   = 4;
    localparam int EV_EJECT = 5;
    localparam int EV_LOCK  = 6;

    typedef struct {
        int code;
        int val;
    } ev_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             card_inserted = 1'b0;
    logic             pin_valid = 1'b0;
    logic             pin_correct = 1'b0;
    logic             amt_valid = 1'b0;
    logic [AMT_W-1:0] amount = '0;
    logic [AMT_W-1:0] balance = '0;
    logic             dispense_cash;
    logic             card_eject;
    logic             card_retained;
    logic             txn_denied;
    logic             txn_timeout;
    logic             debit_valid;
    logic [AMT_W-1:0] debit_amt;
    logic             busy;

    int   checks = 0;
    int   failures = 0;
    ev_t  exp_q[$];
    logic prev_ej = 1'b0;
    logic prev_rt = 1'b0;

    atm_txn_ctrl #(
        .AMT_W(AMT_W),
        .MAX_PIN_TRIES(TRIES),
        .TIMEOUT_CYC(TMO),
        .MAX_NOTES(CAP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .card_inserted(card_inserted),
        .pin_valid(pin_valid),
        .pin_correct(pin_correct),
        .amt_valid(amt_valid),
        .amount(amount),
        .balance(balance),
        .dispense_cash(dispense_cash),
        .card_eject(card_eject),
        .card_retained(card_retained),
        .txn_denied(txn_denied),
        .txn_timeout(txn_timeout),
        .debit_valid(debit_valid),
        .debit_amt(debit_amt),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int code, input int val);
        ev_t e;
        e.code = code;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic obs(input int code, input int val);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected actual_event=%0d/%0d required=none t=%0t", code, val, $time);
        end else begin
            e = exp_q.pop_front();
            if (e.code != code || e.val != val) begin
                failures++;
                $display("FAIL sb_event actual=%0d/%0d required=%0d/%0d t=%0t",
                         code, val, e.code, e.val, $time);
            end
        end
    endtask

    // Event order within one cycle is fixed so pushes can mirror it
    task automatic mon_step();
        if (dispense_cash)             obs(EV_NOTE, 0);
        if (debit_valid)               obs(EV_DEBIT, int'(debit_amt));
        if (txn_denied)                obs(EV_DENY, 0);
        if (txn_timeout)               obs(EV_TMO, 0);
        if (card_eject && !prev_ej)    obs(EV_EJECT, 0);
        if (card_retained && !prev_rt) obs(EV_LOCK, 0);
        prev_ej = card_eject;
        prev_rt = card_retained;
    endtask

    task automatic finish_session();
        card_inserted = 1'b0;
        tick();
        check("return_idle", int'(busy), 0);
    endtask

    task automatic timeout_path();
        push(EV_TMO, 0);
        push(EV_EJECT, 0);
        repeat (TMO - 1) tick();
        check("pre_timeout", int'(card_eject), 0);
        tick();
        check("timeout_edge", int'(card_eject), 1);
        finish_session();
    endtask

    // abort: 0 none, 1 remove in WAIT_AMT, 2 remove while dispensing,
    //        3 remove together with a PIN strobe, 4 remove in CHECK_BAL
    task automatic session(input int wrong, input int pgap, input int agap,
                           input int amt, input int bal, input int abort);
        bit accept;
        int n;
        card_inserted = 1'b1;
        balance = AMT_W'(bal);
        tick();
        if (abort == 3) begin
            card_inserted = 1'b0;
            pin_valid = 1'b1;
            pin_correct = 1'b1;
            tick();
            pin_valid = 1'b0;
            check("abort_pin_idle", int'(busy), 0);
            return;
        end
        for (int i = 0; i <= wrong; i++) begin
            if (pgap >= TMO) begin
                timeout_path();
                return;
            end
            repeat (pgap) tick();
            pin_valid = 1'b1;
            pin_correct = (i == wrong);
            if (i != wrong && i + 1 == TRIES) push(EV_LOCK, 0);
            tick();
            pin_valid = 1'b0;
            pin_correct = 1'b0;
            if (i != wrong && i + 1 == TRIES) begin
                repeat (3) tick();
                check("locked_retained", int'(card_retained), 1);
                finish_session();
                return;
            end
        end
        if (abort == 1) begin
            card_inserted = 1'b0;
            tick();
            check("abort_amt_idle", int'(busy), 0);
            return;
        end
        if (agap >= TMO) begin
            timeout_path();
            return;
        end
        repeat (agap) tick();
        amount = AMT_W'(amt);
        accept = (amt != 0) && (amt <= bal) && (amt <= CAP);
        if (abort != 4) begin
            if (accept) begin
                for (int k = 0; k < amt; k++) push(EV_NOTE, 0);
                push(EV_DEBIT, amt);
            end else begin
                push(EV_DENY, 0);
            end
            push(EV_EJECT, 0);
        end
        amt_valid = 1'b1;
        tick();
        amt_valid = 1'b0;
        check("check_bal_quiet", int'(dispense_cash), 0);
        if (abort == 4) begin
            card_inserted = 1'b0;
            tick();
            check("abort_chk_idle", int'(busy), 0);
            return;
        end
        tick();
        check("first_note", int'(dispense_cash), int'(accept));
        if (abort == 2 && accept) card_inserted = 1'b0;
        n = 0;
        while (!card_eject && n < 200) begin
            tick();
            n++;
        end
        check("eject_reached", int'(card_eject), 1);
        finish_session();
    endtask

    task automatic reset_mid_dispense();
        card_inserted = 1'b1;
        balance = AMT_W'(10);
        tick();
        pin_valid = 1'b1;
        pin_correct = 1'b1;
        tick();
        pin_valid = 1'b0;
        pin_correct = 1'b0;
        amount = AMT_W'(5);
        push(EV_NOTE, 0);
        push(EV_NOTE, 0);
        amt_valid = 1'b1;
        tick();
        amt_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("rst_dispense", int'(dispense_cash), 0);
        check("rst_debit_valid", int'(debit_valid), 0);
        check("rst_debit_amt", int'(debit_amt), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_eject", int'(card_eject), 0);
        card_inserted = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_idle", int'(busy), 0);
    endtask

    initial begin
        int wrong, pgap, agap, amt, bal, abort, lim;
        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        check("reset_dispense", int'(dispense_cash), 0);
        check("reset_eject", int'(card_eject), 0);
        check("reset_retained", int'(card_retained), 0);
        check("reset_denied", int'(txn_denied), 0);
        check("reset_timeout", int'(txn_timeout), 0);
        check("reset_debit_valid", int'(debit_valid), 0);
        check("reset_debit_amt", int'(debit_amt), 0);
        check("reset_busy", int'(busy), 0);
        rst_n = 1'b1;
        tick();

        // Directed scenarios
        session(0, 0, 0, 5, 10, 0);
        session(3, 0, 0, 5, 10, 0);
        session(2, 0, 0, 3, 10, 0);
        session(0, 1, 0, 11, 10, 0);
        session(0, 0, 1, 0, 10, 0);
        session(0, 0, 0, 41, 50, 0);
        session(0, 0, 0, 40, 40, 0);
        session(0, TMO, 0, 5, 10, 0);
        session(0, TMO - 1, 0, 2, 10, 0);
        session(0, 0, TMO, 5, 10, 0);
        session(0, 0, TMO - 1, 1, 1, 0);
        session(0, 0, 0, 5, 10, 1);
        session(0, 0, 0, 6, 10, 2);
        session(0, 0, 0, 5, 10, 3);
        session(1, 0, 0, 5, 10, 4);
        reset_mid_dispense();
        session(0, 0, 0, 7, 20, 0);

        // Randomised sessions
        for (int s = 0; s < 40; s++) begin
            wrong = ($urandom_range(0, 5) == 0) ? 3 : $urandom_range(0, 2);
            pgap  = ($urandom_range(0, 7) == 0) ? TMO : $urandom_range(0, TMO - 1);
            agap  = ($urandom_range(0, 7) == 0) ? TMO : $urandom_range(0, TMO - 1);
            bal   = $urandom_range(0, 60);
            lim   = (bal < CAP) ? bal : CAP;
            case ($urandom_range(0, 5))
                0: amt = 0;
                1: amt = bal + 1;
                2: amt = CAP + 1;
                default: amt = (lim > 0) ? $urandom_range(1, lim) : 0;
            endcase
            abort = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            session(wrong, pgap, agap, amt, bal, abort);
        end

        repeat (5) tick();
        check("sb_drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/atm_txn_ctrl.md
# atm_txn_ctrl

Parametrised ATM transaction controller. It replaces the fixed 4-state PIN/balance FSM with a full transaction sequence: PIN entry with a bounded retry count and card retention, a requested note amount checked against the account balance and a per-transaction cap, multi-cycle note dispensing, and inactivity timeouts. It sits between the card/keypad front end and the cash-dispenser mechanism, and reports each completed debit to the accounting logic.

## Interface
- `AMT_W`, 8: width of the amount and balance fields, counted in notes.
- `MAX_PIN_TRIES`, 3: number of wrong PINs (≥1) that causes the card to be retained.
- `TIMEOUT_CYC`, 255: idle cycles (≥1) allowed in a waiting state before the card is ejected.
- `MAX_NOTES`, 40: largest number of notes per transaction (≥1, ≤2^AMT_W−1).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `card_inserted` in 1: level; card is present in the slot.
- `pin_valid` in 1: one-cycle strobe; a PIN entry is complete.
- `pin_correct` in 1: PIN compare result; sampled only when `pin_valid`=1.
- `amt_valid` in 1: one-cycle strobe; `amount` is valid.
- `amount` in AMT_W: number of notes requested.
- `balance` in AMT_W: account balance in notes; sampled in CHECK_BAL.
- `dispense_cash` out 1: high one cycle per note released.
- `card_eject` out 1: level; the card is being returned.
- `card_retained` out 1: level; the card has been captured.
- `txn_denied` out 1: one-cycle pulse; the amount was rejected.
- `txn_timeout` out 1: one-cycle pulse; an inactivity timeout occurred.
- `debit_valid` out 1: one-cycle pulse; a debit has completed.
- `debit_amt` out AMT_W: notes debited; held until the next debit.
- `busy` out 1: high whenever the controller is not in IDLE.

## Operation
- States are IDLE, WAIT_PIN, WAIT_AMT, CHECK_BAL, DISPENSE, EJECT and LOCKED.
- **IDLE:** `card_inserted`=1 → WAIT_PIN. The retry counter is cleared and the timer is loaded.
- **WAIT_PIN:**
  - `pin_valid` & `pin_correct` → WAIT_AMT, and the timer is reloaded.
  - `pin_valid` & !`pin_correct` → the retry counter increments.
    - If the count reaches MAX_PIN_TRIES → LOCKED.
    - Otherwise the state stays in WAIT_PIN and the timer is reloaded.
- **WAIT_AMT:** `amt_valid` → `amount` is captured into the note register, then → CHECK_BAL.
- **Timeout (WAIT_PIN and WAIT_AMT):**
  - A transition is triggered by `TIMEOUT_CYC` consecutive cycles with no strobe in the state.
  - Result: → EJECT, with `txn_timeout` pulsed in the first EJECT cycle.
- **CHECK_BAL** (always exactly one cycle):
  - Accept when `amount` ≠ 0, `amount` ≤ `balance` and `amount` ≤ MAX_NOTES. → DISPENSE.
  - Reject otherwise. → EJECT, with `txn_denied` pulsed in the first EJECT cycle.
  - All comparisons are unsigned and AMT_W wide.
- **DISPENSE:**
  - `dispense_cash`=1 every cycle, and the note register decrements each cycle.
  - After exactly `amount` cycles → EJECT.
  - `debit_valid` pulses and `debit_amt` = the captured amount, both in the first EJECT cycle.
- **EJECT:** `card_eject`=1 until `card_inserted`=0, then → IDLE.
- **LOCKED:** `card_retained`=1 until `card_inserted`=0, then → IDLE.
  - Neither `dispense_cash` nor `card_eject` is ever asserted here.
- **Card removal** (`card_inserted`=0):
  - In WAIT_PIN, WAIT_AMT or CHECK_BAL → immediate IDLE. No pulse, no debit, and the counters are cleared.
  - In DISPENSE it is ignored; dispensing completes.
- **Simultaneous events:**
  - Card removal beats a strobe.
  - A strobe beats a timeout in the same cycle.
  - `pin_valid` in WAIT_AMT and `amt_valid` in WAIT_PIN are ignored.
- **Invariants:**
  - `dispense_cash` is never high unless a correct PIN and an accepted amount were both seen in the current session.
  - The number of `dispense_cash` cycles always equals `debit_amt`.

## Timing
- **Reset:** state = IDLE, and all outputs are 0 (`debit_amt`=0). The retry counter and timer are cleared.
- **Output decode:**
  - `dispense_cash`, `card_eject`, `card_retained` and `busy` are decoded from the registered state only; no input-to-output combinational path.
  - The pulses are registered flags.
- **Insertion:** `card_inserted` sampled at edge e → WAIT_PIN after e.
- **Amount to first note:** `amt_valid` sampled at edge e → CHECK_BAL after e → DISPENSE after e+1. The first `dispense_cash` cycle is e+1..e+2.
- **Dispense length:** N notes means `dispense_cash` is high for exactly N consecutive cycles, followed by EJECT.
- **Timer:** reloads on state entry and on each accepted strobe. The timeout edge is the TIMEOUT_CYC-th idle edge.
- **Mid-operation reset:**
  - `rst_n` low forces IDLE asynchronously.
  - `dispense_cash` drops within the same cycle.
  - No `debit_valid` is generated for a partial dispense.

## Test plan
- **Happy path.** card=1; correct PIN; `amount`=5, `balance`=10. Expect 5 consecutive `dispense_cash` cycles, then `debit_valid` with `debit_amt`=5, `card_eject`=1, and IDLE after card=0.
- **Lockout** (MAX_PIN_TRIES=3). Three wrong PINs. Expect LOCKED, `card_retained`=1, zero `dispense_cash`. Two wrong PINs then a correct one must still reach WAIT_AMT.
- **Denials.** `amount`=11 with `balance`=10; `amount`=0; `amount`=41 with MAX_NOTES=40. Each gives a single `txn_denied`, no dispense, and EJECT. `amount`=`balance`=40 is accepted, giving 40 notes.
- **Timeout** (TIMEOUT_CYC=4). No PIN for 4 cycles → `txn_timeout`, then EJECT. A `pin_valid` on cycle 4 wins instead.
- **Abort.** Card removed in WAIT_AMT → IDLE next cycle, no pulses. Card removed during DISPENSE → all notes are still dispensed.
- **Reset mid-dispense.** `rst_n`=0 after 2 of 5 notes → all outputs 0 immediately, no `debit_valid`, and a fresh transaction works afterwards.
